axis_slice_chain: RTL

//  Parametrised chain of valid/ready register slices for a single data stream with a fixed add-offset transform.

---
 rtl/axis_slice_chain.sv | 119 +++++++++++
 1 files changed

// File: rtl/axis_slice_chain.sv
// Chain of valid/ready register slices carrying one data stream; stage 0 adds INC_VAL to every beat.
// FULL_SLICE=1 builds skid stages with a flopped ready; FULL_SLICE=0 builds forward-only stages.
module axis_slice_chain #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned INC_VAL    = 1,
  parameter bit          FULL_SLICE = 1'b1
) (
  input  logic                                aclk_i,
  input  logic                                areset_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [DWIDTH-1:0]                   data_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [DWIDTH-1:0]                   data_o,
  output logic [$clog2(2*STAGES+1)-1:0]       level_o
);

  localparam int unsigned LW = $clog2(2*STAGES+1);

  logic              run_q;
  logic [STAGES-1:0] mv_q, mv_n, sv_q, sv_n;
  logic [DWIDTH-1:0] md_q [STAGES];
  logic [DWIDTH-1:0] md_n [STAGES];
  logic [DWIDTH-1:0] sd_q [STAGES];
  logic [DWIDTH-1:0] sd_n [STAGES];
  logic [LW-1:0]     level_q;

  // Link s feeds stage s; link STAGES is the chain output.
  logic [STAGES:0]   lv;
  logic [STAGES:0]   lr;
  logic [DWIDTH-1:0] ld [STAGES+1];
  logic              acc_c, dlv_c;

  assign lv = {mv_q, valid_i & run_q};

  always_comb begin
    ld[0] = DWIDTH'(data_i + DWIDTH'(INC_VAL));
    for (int s = 0; s < int'(STAGES); s++) begin
      ld[s+1] = md_q[s];
    end
  end

  // Stage readiness: skid stages use the flopped skid flag, forward stages look downstream.
  always_comb begin
    lr = '0;
    lr[STAGES] = ready_i;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      if (FULL_SLICE) lr[s] = ~sv_q[s];
      else            lr[s] = ~mv_q[s] | lr[s+1];
    end
  end

  // Next-state for every stage's main and skid registers.
  always_comb begin
    mv_n = mv_q;
    sv_n = sv_q;
    md_n = md_q;
    sd_n = sd_q;
    for (int s = 0; s < int'(STAGES); s++) begin
      if (FULL_SLICE) begin
        if (sv_q[s]) begin
          if (lr[s+1]) begin
            md_n[s] = sd_q[s];
            sv_n[s] = 1'b0;
          end
        end else if (lv[s]) begin
          if (mv_q[s] && !lr[s+1]) begin
            sv_n[s] = 1'b1;
            sd_n[s] = ld[s];
          end else begin
            mv_n[s] = 1'b1;
            md_n[s] = ld[s];
          end
        end else begin
          mv_n[s] = mv_q[s] & ~lr[s+1];
        end
      end else if (lr[s]) begin
        mv_n[s] = lv[s];
        if (lv[s]) md_n[s] = ld[s];
      end
    end
  end

  assign acc_c = valid_i & ready_o;
  assign dlv_c = valid_o & ready_i;

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      run_q   <= 1'b0;
      mv_q    <= '0;
      sv_q    <= '0;
      level_q <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        md_q[s] <= '0;
        sd_q[s] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      mv_q  <= mv_n;
      sv_q  <= sv_n;
      md_q  <= md_n;
      sd_q  <= sd_n;
      case ({acc_c, dlv_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // run_q holds ready low through reset, including for the combinational forward chain.
  assign ready_o = run_q & lr[0];
  assign valid_o = lv[STAGES];
  assign data_o  = ld[STAGES];
  assign level_o = level_q;

endmodule
